ccr_unit: RTL and testbench

Condition-code register (CCR) for the 8-bit RISC core, directly downstream of the ALU in the execute stage. It does four things:
- Commits the ALU's C/V/N/Z flags.
- Feeds the committed flags back to the ALU's old-flag inputs.
- Evaluates conditional-jump conditions and clears the tested flag when a jump is taken.
- Saves and restores flags on interrupt entry and RTI through a small LIFO shadow stack.

---
 rtl/risc_pkg.sv | 23 ++
 rtl/flag_stack.sv | 57 +++++
 rtl/ccr_unit.sv | 112 +++++++++++
 tb/tb_ccr_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared flag and condition definitions for the 8-bit RISC core.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package risc_pkg;

    // Bit positions of the condition flags inside flags_t.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Conditional-jump condition select encodings.
    typedef enum logic [1:0] {
        JC_Z = 2'b00,
        JC_N = 2'b01,
        JC_C = 2'b10,
        JC_V = 2'b11
    } jcond_t;

    // 4-bit flag word {C, V, N, Z} shared by the ALU, CCR and hazard unit.
    typedef logic [3:0] flags_t;

endpackage

// File: rtl/flag_stack.sv
// LIFO of flag words used to shadow the CCR across nested interrupts.
// Latency: push/pop take effect at the next rising edge; top is combinational from stored state.
// Backpressure: none; push when full and pop when empty are ignored (caller flags the error).
module flag_stack
    import risc_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  flags_t        din,
    output flags_t        top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    flags_t        mem [DEPTH];
    logic [DW-1:0] cnt;

    assign depth = cnt;
    assign full  = (cnt == DW'(DEPTH));
    assign empty = (cnt == '0);

    // Push writes the slot just above the current top; pop only moves the pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt == DW'(i)) begin
                    mem[i] <= din;
                end
            end
            cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Top of stack is the entry just below the occupancy pointer; zero when empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt == DW'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register: commits ALU flags, resolves conditional jumps, shadows flags on interrupts.
// Latency: ccr_* and depth update 1 cycle after the commit/push/pop; jump_taken is combinational.
// Backpressure: stall freezes all state and forces jump_taken low; no internal busy state.
module ccr_unit
    import risc_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          alu_c,
    input  logic          alu_v,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          flag_we,
    input  logic          jc_valid,
    input  logic [1:0]    jcond,
    input  logic          int_save,
    input  logic          rti_restore,
    output logic          ccr_c,
    output logic          ccr_v,
    output logic          ccr_n,
    output logic          ccr_z,
    output logic          jump_taken,
    output logic [DW-1:0] depth,
    output logic          stack_ovf,
    output logic          stack_unf
);

    flags_t     ccr;
    flags_t     retire_flags;
    flags_t     stack_top;
    logic [1:0] jbit;
    logic       stk_full;
    logic       stk_empty;
    logic       save_only;
    logic       restore_only;
    logic       do_push;
    logic       do_pop;

    assign ccr_c = ccr[FLAG_C];
    assign ccr_v = ccr[FLAG_V];
    assign ccr_n = ccr[FLAG_N];
    assign ccr_z = ccr[FLAG_Z];

    // Map the jump condition select onto the flag bit it tests.
    always_comb begin
        jbit = 2'(FLAG_Z);
        case (jcond)
            JC_Z:    jbit = 2'(FLAG_Z);
            JC_N:    jbit = 2'(FLAG_N);
            JC_C:    jbit = 2'(FLAG_C);
            JC_V:    jbit = 2'(FLAG_V);
            default: jbit = 2'(FLAG_Z);
        endcase
    end

    // Jumps test the registered flags only; the hazard unit keeps dependent writes out of EX.
    assign jump_taken = jc_valid & ~flush & ~stall & ccr[jbit];

    // Flags after the current instruction retires: commit, then clear the tested bit on a taken jump.
    always_comb begin
        retire_flags = ccr;
        if (flag_we && !flush) begin
            retire_flags = {alu_c, alu_v, alu_n, alu_z};
        end
        if (jump_taken) begin
            retire_flags[jbit] = 1'b0;
        end
    end

    // Simultaneous save and restore cancel on the stack; only lone requests touch it.
    assign save_only    = int_save & ~rti_restore;
    assign restore_only = rti_restore & ~int_save;
    assign do_push      = ~stall & save_only & ~stk_full;
    assign do_pop       = ~stall & restore_only & ~stk_empty;

    flag_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (do_push),
        .pop   (do_pop),
        .din   (retire_flags),
        .top   (stack_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // CCR register and sticky stack error flags; a successful pop overrides the retired flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ccr       <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!stall) begin
            ccr <= do_pop ? stack_top : retire_flags;
            if (save_only && stk_full) begin
                stack_ovf <= 1'b1;
            end
            if (restore_only && stk_empty) begin
                stack_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic       alu_c, alu_v, alu_n, alu_z;
    logic       flag_we;
    logic       jc_valid;
    logic [1:0] jcond;
    logic       int_save;
    logic       rti_restore;
    logic       ccr_c, ccr_v, ccr_n, ccr_z;
    logic       jump_taken;
    logic [1:0] depth;
    logic       stack_ovf;
    logic       stack_unf;

    ccr_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .flag_we     (flag_we),
        .jc_valid    (jc_valid),
        .jcond       (jcond),
        .int_save    (int_save),
        .rti_restore (rti_restore),
        .ccr_c       (ccr_c),
        .ccr_v       (ccr_v),
        .ccr_n       (ccr_n),
        .ccr_z       (ccr_z),
        .jump_taken  (jump_taken),
        .depth       (depth),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: flags as a word {C,V,N,Z}, shadow stack as a queue.
    logic [3:0] m_ccr;
    logic [3:0] m_stk[$];
    logic       m_ovf;
    logic       m_unf;
    logic       last_jt;
    int         cond_bit[4] = '{0, 1, 3, 2};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs_ccr();
        return {ccr_c, ccr_v, ccr_n, ccr_z};
    endfunction

    // One cycle: drive inputs, check jump_taken before the edge, advance the model, check after.
    task automatic step(input logic r, input logic st, input logic fl, input logic we,
                        input logic [3:0] alu, input logic jc, input logic [1:0] jsel,
                        input logic sv, input logic rt);
        logic       exp_jt;
        logic [3:0] nxt;
        @(negedge clk);
        rst_n = r; stall = st; flush = fl; flag_we = we;
        {alu_c, alu_v, alu_n, alu_z} = alu;
        jc_valid = jc; jcond = jsel; int_save = sv; rti_restore = rt;
        #1;
        exp_jt  = jc && !fl && !st && m_ccr[cond_bit[jsel]];
        last_jt = jump_taken;
        chk("jump_taken", {7'd0, jump_taken}, {7'd0, exp_jt});
        if (!r) begin
            m_ccr = 4'b0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (!st) begin
            nxt = m_ccr;
            if (we && !fl) nxt = alu;
            if (exp_jt) nxt[cond_bit[jsel]] = 1'b0;
            if (sv && rt) begin
                m_ccr = nxt;
            end else if (sv) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
                else m_ovf = 1'b1;
                m_ccr = nxt;
            end else if (rt) begin
                if (m_stk.size() > 0) m_ccr = m_stk.pop_back();
                else begin
                    m_unf = 1'b1;
                    m_ccr = nxt;
                end
            end else begin
                m_ccr = nxt;
            end
        end
        @(posedge clk);
        #1;
        chk("ccr",       {4'd0, obs_ccr()},   {4'd0, m_ccr});
        chk("depth",     {6'd0, depth},       8'(m_stk.size()));
        chk("stack_ovf", {7'd0, stack_ovf},   {7'd0, m_ovf});
        chk("stack_unf", {7'd0, stack_unf},   {7'd0, m_unf});
    endtask

    initial begin
        m_ccr = 4'b0000; m_ovf = 1'b0; m_unf = 1'b0; last_jt = 1'b0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flag_we = 1'b0;
        {alu_c, alu_v, alu_n, alu_z} = 4'b0000;
        jc_valid = 1'b0; jcond = 2'b00; int_save = 1'b0; rti_restore = 1'b0;

        // Reset then commit {C1,V0,N1,Z0}.
        step(0, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        chk("reset_ccr", {4'd0, obs_ccr()}, 8'h00);
        step(1, 0, 0, 1, 4'b1010, 0, 2'b00, 0, 0);
        chk("commit_1010", {4'd0, obs_ccr()}, 8'h0A);

        // Taken jump on Z clears Z only.
        step(1, 0, 0, 1, 4'b0101, 0, 2'b00, 0, 0);
        step(1, 0, 0, 0, 4'b0000, 1, 2'b00, 0, 0);
        chk("jt_z_taken", {7'd0, last_jt}, 8'h01);
        chk("jt_z_clear", {4'd0, obs_ccr()}, 8'h04);

        // Taken jump beats a same-cycle write of Z=1.
        step(1, 0, 0, 1, 4'b0011, 0, 2'b00, 0, 0);
        step(1, 0, 0, 1, 4'b1001, 1, 2'b00, 0, 0);
        chk("jt_beats_we", {4'd0, obs_ccr()}, 8'h08);

        // Flush suppresses both the commit and the jump.
        step(1, 0, 0, 1, 4'b0001, 0, 2'b00, 0, 0);
        step(1, 0, 1, 1, 4'b1111, 1, 2'b00, 0, 0);
        chk("flush_no_jt", {7'd0, last_jt}, 8'h00);
        chk("flush_hold", {4'd0, obs_ccr()}, 8'h01);

        // Nested save/restore with overflow.
        step(0, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        step(1, 0, 0, 1, 4'b0001, 0, 2'b00, 1, 0);
        step(1, 0, 0, 1, 4'b1000, 0, 2'b00, 1, 0);
        step(1, 0, 0, 1, 4'b0100, 0, 2'b00, 1, 0);
        chk("ovf_set", {7'd0, stack_ovf}, 8'h01);
        chk("ovf_depth", {6'd0, depth}, 8'h02);
        step(1, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1);
        chk("rti1", {4'd0, obs_ccr()}, 8'h08);
        step(1, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1);
        chk("rti2", {4'd0, obs_ccr()}, 8'h01);
        chk("rti_depth0", {6'd0, depth}, 8'h00);

        // Underflow, then simultaneous save+restore at depth 1.
        step(1, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1);
        chk("unf_set", {7'd0, stack_unf}, 8'h01);
        chk("unf_hold", {4'd0, obs_ccr()}, 8'h01);
        step(1, 0, 0, 0, 4'b0000, 0, 2'b00, 1, 0);
        step(1, 0, 0, 1, 4'b0110, 0, 2'b00, 1, 1);
        chk("both_depth", {6'd0, depth}, 8'h01);
        step(1, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1);
        chk("both_top", {4'd0, obs_ccr()}, 8'h01);

        // Stall freezes everything.
        step(1, 0, 0, 1, 4'b1111, 0, 2'b00, 0, 0);
        step(1, 1, 0, 1, 4'b0000, 1, 2'b00, 1, 0);
        chk("stall_no_jt", {7'd0, last_jt}, 8'h00);
        chk("stall_hold", {4'd0, obs_ccr()}, 8'h0F);

        // Reset wins over a pending push.
        step(0, 0, 0, 1, 4'b1111, 0, 2'b00, 1, 0);
        chk("rst_all", {obs_ccr(), depth, stack_ovf, stack_unf}, 8'h00);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom),
                 1'($urandom_range(0, 1)),
                 2'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
